// File: rtl/scan_generator.sv
// rtl/scan_generator.sv - horizontal/vertical scan position generator with frame-aligned run/stop
module scan_generator #(
  parameter int h_width  = 10,
  parameter int v_width  = 10,
  parameter int h_total  = 800,
  parameter int v_total  = 525,
  parameter int prescale = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [h_width-1:0] h_count,
  output logic [v_width-1:0] v_count,
  output logic               h_enable,
  output logic               v_enable,
  output logic               frame_end,
  output logic               busy
);

  localparam int pre_width = (prescale > 1) ? $clog2(prescale) : 1;
  localparam logic [pre_width-1:0] pre_last = pre_width'(prescale - 1);
  localparam logic [h_width-1:0]   h_last   = h_width'(h_total - 1);
  localparam logic [v_width-1:0]   v_last   = v_width'(v_total - 1);

  typedef enum logic [1:0] {IDLE, SCAN, LAST} state_t;

  state_t               state, state_next;
  logic [pre_width-1:0] pre;
  logic                 line_last;
  logic                 column_last;

  // All enables come from registered state only, so run never reaches them combinationally.
  assign busy        = (state != IDLE);
  assign h_enable    = busy && (pre == pre_last);
  assign line_last   = (h_count == h_last);
  assign column_last = (v_count == v_last);
  assign v_enable    = h_enable && line_last;
  assign frame_end   = v_enable && column_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (run) state_next = SCAN;
      SCAN: begin
        if (frame_end) state_next = run ? SCAN : IDLE;
        else if (!run) state_next = LAST;
      end
      LAST: if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre     <= '0;
      h_count <= '0;
      v_count <= '0;
    end else if (state == IDLE || state_next == IDLE) begin
      pre     <= '0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      pre <= (pre == pre_last) ? '0 : pre + pre_width'(1);
      if (h_enable) begin
        h_count <= line_last ? '0 : h_count + h_width'(1);
        if (line_last) v_count <= column_last ? '0 : v_count + v_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_generator.sv
// tb/tb_scan_generator.sv - directed self-checking bench for scan_generator
module tb_scan_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       run2;
  logic [3:0] h_count, v_count;
  logic       h_enable, v_enable, frame_end, busy;
  logic [0:0] h_count2, v_count2;
  logic       h_enable2, v_enable2, frame_end2, busy2;
  logic [11:0] obs1, obs2;
  int checks = 0;
  int fails  = 0;
  int pulses;
  int busy_seen;

  always #5 clock = ~clock;

  scan_generator #(.h_width(4), .v_width(4), .h_total(4), .v_total(3), .prescale(2)) dut (
    .clock(clock), .reset(reset), .run(run),
    .h_count(h_count), .v_count(v_count),
    .h_enable(h_enable), .v_enable(v_enable), .frame_end(frame_end), .busy(busy)
  );

  scan_generator #(.h_width(1), .v_width(1), .h_total(2), .v_total(2), .prescale(1)) dut2 (
    .clock(clock), .reset(reset), .run(run2),
    .h_count(h_count2), .v_count(v_count2),
    .h_enable(h_enable2), .v_enable(v_enable2), .frame_end(frame_end2), .busy(busy2)
  );

  assign obs1 = {busy, h_enable, v_enable, frame_end, h_count, v_count};
  assign obs2 = {6'b0, busy2, h_enable2, v_enable2, frame_end2, h_count2, v_count2};

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs c clocks after the edge that starts a 4x3, prescale 2 frame.
  function automatic logic [11:0] m1(input int c);
    int p, h, v;
    logic he, ve, fe;
    p  = (c / 2) % 12;
    h  = p % 4;
    v  = p / 4;
    he = (c % 2) == 1;
    ve = he && (h == 3);
    fe = ve && (v == 2);
    return {1'b1, he, ve, fe, 4'(h), 4'(v)};
  endfunction

  // Expected outputs for the 2x2, prescale 1 instance.
  function automatic logic [11:0] m2(input int c);
    int p, h, v;
    logic ve, fe;
    p  = c % 4;
    h  = p % 2;
    v  = p / 2;
    ve = (h == 1);
    fe = ve && (v == 1);
    return {6'b0, 1'b1, 1'b1, ve, fe, 1'(h), 1'(v)};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; run = 1'b0; run2 = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_async", obs1, 12'h000);
    check("reset_async2", obs2, 12'h000);
    @(negedge clock);
    reset = 1'b0;

    pulses = 0; busy_seen = 0;
    repeat (100) begin
      @(negedge clock);
      if (h_enable) pulses++;
      if (busy) busy_seen++;
    end
    check("idle_h_enable", 12'(pulses), 12'd0);
    check("idle_busy", 12'(busy_seen), 12'd0);

    // Continuous run into a second frame, stop at (1,1), run re-raised while finishing.
    run = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clock);
      check($sformatf("run_c%0d", c), obs1, m1(c));
      if (c == 34) run = 1'b0;
      if (c == 40) run = 1'b1;
    end
    @(negedge clock);
    check("stop_idle", obs1, 12'h000);

    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      check($sformatf("restart_c%0d", c), obs1, m1(c));
    end

    // Asynchronous reset at (2,1).
    #1 reset = 1'b1;
    #1;
    check("reset_mid", obs1, 12'h000);
    @(negedge clock);
    check("reset_hold", obs1, 12'h000);
    reset = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      check($sformatf("post_reset_c%0d", c), obs1, m1(c));
      if (c == 0) run = 1'b0;
    end
    @(negedge clock);
    check("post_reset_idle", obs1, 12'h000);

    // run first seen low at the frame_end edge.
    run = 1'b1;
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      check($sformatf("boundary_c%0d", c), obs1, m1(c));
      if (h_enable) pulses++;
      if (c == 23) run = 1'b0;
    end
    check("boundary_pulses", 12'(pulses), 12'd12);
    pulses = 0; busy_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (h_enable) pulses++;
      if (busy) busy_seen++;
    end
    check("boundary_no_enable", 12'(pulses), 12'd0);
    check("boundary_no_busy", 12'(busy_seen), 12'd0);

    // Single-clock run pulse on the prescale 1 instance.
    run2 = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check($sformatf("pulse2_c%0d", c), obs2, m2(c));
      if (h_enable2) pulses++;
      run2 = 1'b0;
    end
    repeat (3) begin
      @(negedge clock);
      check("pulse2_idle", obs2, 12'h000);
      if (h_enable2) pulses++;
    end
    check("pulse2_pixels", 12'(pulses), 12'd4);

    run2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check($sformatf("cont2_c%0d", c), obs2, m2(c));
      if (c == 5) run2 = 1'b0;
    end
    @(negedge clock);
    check("cont2_idle", obs2, 12'h000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/scan_generator.md
# scan_generator

- Produces the upward-counting horizontal and vertical scan positions, with qualifying enables, that feed the design's range counters.
- Horizontal position advances once per pixel tick; a pixel tick is every `prescale` clocks.
- Vertical position advances when the horizontal position wraps.
- A run/stop control always stops on a frame boundary, so downstream range counters never see a truncated frame.

## Interface
- `h_width`, default 10: width of `h_count`.
- `v_width`, default 10: width of `v_count`.
- `h_total`, default 800: pixel ticks per line. Range is 2 to 2^h_width.
- `v_total`, default 525: lines per frame. Range is 2 to 2^v_width.
- `prescale`, default 2: clocks per pixel tick, minimum 1.
- `clock`  in  1  single clock. All state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level request to scan. Sampled every clock.
- `h_count`  out  h_width  current horizontal position, 0..h_total-1.
- `v_count`  out  v_width  current vertical position, 0..v_total-1.
- `h_enable`  out  1  high for one clock at the end of each pixel tick.
- `v_enable`  out  1  high with `h_enable` when `h_count == h_total-1`.
- `frame_end`  out  1  high with `v_enable` when `v_count == v_total-1`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Internal prescaler `pre` counts 0..prescale-1. It is held at 0 in IDLE. For `prescale`=1 it is constantly 0.
- State machine:
  - IDLE: counters and `pre` held at 0. `run`=1 moves to SCAN.
  - SCAN: scanning. `run`=0 sampled at any edge moves to LAST. Counting continues without interruption.
  - LAST: finishes the current frame; `run` is ignored. The edge where `frame_end`=1 moves to IDLE.
  - SCAN with `run`=1 at the `frame_end` edge stays in SCAN and wraps to 0,0.
  - SCAN with `run`=0 at the `frame_end` edge goes directly to IDLE; LAST is skipped.
- Pixel tick: `h_enable` = (state != IDLE) and (`pre` == prescale-1). It is decoded from registers only, with no combinational path from `run`.
- At a pixel tick edge:
  - `h_count` increments, or wraps to 0 if it is `h_total-1`.
  - On wrap, `v_count` increments, or wraps to 0 if it is `v_total-1`.
- `v_enable` and `frame_end` are decoded from the same registers as `h_enable`, so all three coincide on the final clock of a pixel.
- Consumers sample `h_count`/`v_count` when `h_enable`=1. The values are stable for all `prescale` clocks of a pixel.
- Entering IDLE forces `h_count`, `v_count` and `pre` to 0. Every scan therefore starts at 0,0.
- Arithmetic is unsigned. Counters never exceed `total-1`, so no overflow past the parameter range is possible.

## Timing
- Reset values: state IDLE; `h_count`, `v_count`, `pre` = 0; `h_enable`, `v_enable`, `frame_end`, `busy` = 0.
- Reset applies immediately (asynchronous). It may occur mid-frame; the next frame restarts at 0,0 with no partial output.
- Start latency:
  - `run` sampled high at edge k gives `busy`=1 after edge k.
  - The first `h_enable` occurs in the clock after edge k+prescale-1, with `h_count`=0, `v_count`=0.
- Pixel ticks occur every `prescale` clocks, with no gaps across line and frame wraps.
- Frame length is exactly `h_total` × `v_total` × `prescale` clocks.
- Stop behaviour:
  - `busy` falls on the edge following the clock where `frame_end`=1.
  - No `h_enable` occurs after that `frame_end`.
- A `run` pulse of a single clock in IDLE starts one complete frame, then the block returns to IDLE.
- Re-assertion of `run` in LAST has no effect. `run` must be high in IDLE to restart, so there is at least one IDLE clock between frames.
- `prescale`=1: `h_enable`=1 on every clock in SCAN and LAST.

## Test plan
Unless stated, `h_total`=4, `v_total`=3, `prescale`=2.
- Reset state: assert `reset` -> all outputs 0 immediately; after release with `run`=0 -> the block stays IDLE for 100 clocks, with no `h_enable`.
- Continuous run: `run` held 1 -> `h_enable` every 2nd clock; `h_count` sequence 0,1,2,3,0; `v_enable` at `h_count`=3; `frame_end` at (3,2); the next pixel is (0,0); 24 clocks per frame.
- Mid-frame stop: drop `run` at (1,1) -> the frame completes to (3,2) with `frame_end`; `busy`=0 on the next clock; counters 0; no further enables.
- Stop at the boundary: `run`=0 first sampled at the `frame_end` edge -> direct SCAN to IDLE; 12 `h_enable` pulses total for that frame.
- Reset mid-frame at (2,1) -> outputs 0 asynchronously; after release with `run`=1 -> the first pixel is (0,0), 2 clocks after `busy` rises.
- `prescale`=1, `h_total`=2, `v_total`=2 -> `h_enable` every clock; `frame_end` every 4th clock; a single-cycle `run` pulse gives exactly 4 pixels.
